// File: rtl/change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// change_dispense_ctrl
//
// Pays out change one denomination at a time, largest first, through a
// valid/ready handshake to the coin/note dispenser. It also keeps a stock
// counter for each denomination. The vending FSM pulses start together with
// the amount owed. This block then walks the denominations 50, 20, 10, 5, 1.
// A denomination is issued when its value still fits into the remaining
// amount and its stock is not empty. Otherwise the walk moves to the next
// smaller denomination. The walk is greedy and never backtracks.
//
// Ports
//   sys_clk        in   system clock, rising edge
//   sys_rst        in   synchronous reset, active-high
//   start          in   payout request (1 cycle), sampled only while idle
//   change_amt     in   amount to pay out, latched on an accepted start
//   cancel         in   abort a payout in progress
//   refill         in   reload every stock counter, honoured only while idle
//   deposit_valid  in   customer inserted one unit of deposit_den
//   deposit_den    in   denomination code 0..4 (1,5,10,20,50); 5..7 ignored
//   disp_valid     out  dispense request
//   disp_den       out  denomination of the request, stable while disp_valid
//   disp_ready     in   dispenser accepts; transfer = disp_valid & disp_ready
//   busy           out  payout in progress (any state but idle)
//   done           out  one-cycle end-of-payout pulse
//   short          out  with done: the full amount could not be paid
//   remain         out  amount still owed, holds until the next start
//   stock_empty    out  bit i set when stock of denomination i is zero
// -----------------------------------------------------------------------------
module change_dispense_ctrl #(
    parameter int AMT_W      = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             cancel,
    input  logic             refill,
    input  logic             deposit_valid,
    input  logic [2:0]       deposit_den,
    output logic             disp_valid,
    output logic [2:0]       disp_den,
    input  logic             disp_ready,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remain,
    output logic [4:0]       stock_empty
);

    localparam int                 NUM_DEN    = 5;
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [AMT_W-1:0]   remain_nxt;
    logic [STOCK_W-1:0] stock [NUM_DEN];

    logic               xfer;
    logic               can_issue;
    logic [AMT_W-1:0]   cur_value;
    logic [NUM_DEN-1:0] take_vec;
    logic [NUM_DEN-1:0] give_vec;
    logic               do_refill;

    function automatic logic [AMT_W-1:0] den_value(input logic [2:0] code);
        case (code)
            3'd4:    den_value = AMT_W'(50);
            3'd3:    den_value = AMT_W'(20);
            3'd2:    den_value = AMT_W'(10);
            3'd1:    den_value = AMT_W'(5);
            default: den_value = AMT_W'(1);
        endcase
    endfunction

    assign cur_value  = den_value(idx);
    assign can_issue  = (cur_value <= remain) && (stock[idx] != '0);
    assign disp_valid = (state == ISSUE);
    assign disp_den   = disp_valid ? idx : 3'd0;
    assign xfer       = disp_valid && disp_ready;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign short      = done && (remain != '0);
    // A start in the same cycle takes priority, so the refill is dropped.
    assign do_refill  = (state == IDLE) && refill && !start;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        remain_nxt = remain;
        case (state)
            IDLE: begin
                if (start) begin
                    remain_nxt = change_amt;
                    idx_nxt    = 3'd4;
                    state_nxt  = SELECT;
                end
            end
            SELECT: begin
                if (cancel)                state_nxt = DONE;
                else if (remain == '0)     state_nxt = DONE;
                else if (can_issue)        state_nxt = ISSUE;
                else if (idx == 3'd0)      state_nxt = DONE;
                else                       idx_nxt   = idx - 3'd1;
            end
            ISSUE: begin
                // A transfer in the same cycle as cancel still completes.
                if (xfer) begin
                    remain_nxt = remain - cur_value;
                    state_nxt  = SELECT;
                end
                if (cancel) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that existed before the edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= IDLE;
            idx    <= 3'd0;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            remain <= remain_nxt;
        end
    end

    always_comb begin
        take_vec = '0;
        give_vec = '0;
        for (int i = 0; i < NUM_DEN; i++) begin
            take_vec[i] = xfer && (idx == 3'(i));
            give_vec[i] = deposit_valid && (deposit_den == 3'(i));
        end
    end

    // NOTE: the stock array is reset on purpose. It is only five small
    // counters, and the machine must power up with known stock.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || do_refill) begin
            for (int i = 0; i < NUM_DEN; i++) stock[i] <= STOCK_INIT;
        end else begin
            for (int i = 0; i < NUM_DEN; i++) begin
                // A deposit and a dispense of the same denomination cancel out.
                if (give_vec[i] && !take_vec[i] && stock[i] != STOCK_MAX)
                    stock[i] <= stock[i] + STOCK_W'(1);
                else if (take_vec[i] && !give_vec[i])
                    stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        stock_empty = '0;
        for (int i = 0; i < NUM_DEN; i++) stock_empty[i] = (stock[i] == '0);
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_change_dispense_ctrl
//
// The bench models the payout at the level of a plan. On each accepted start
// it computes, from the greedy rule and the current stock, the sequence of
// expected cycles: a scan step, an offer of denomination d, and the final
// done. A compare process checks the DUT outputs against the head of that
// plan on every cycle. An offer stays at the head while the dispenser is not
// ready. A cancel replaces the rest of the plan with a single done. Directed
// scenarios then pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_change_dispense_ctrl;

    localparam int AMT_W      = 8;
    localparam int STOCK_W    = 4;
    localparam int INIT_STOCK = 10;
    localparam int K_SCAN  = 0;
    localparam int K_OFFER = 1;
    localparam int K_DONE  = 2;

    typedef struct {
        int kind;
        int den;
    } step_t;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             start;
    logic [AMT_W-1:0] change_amt;
    logic             cancel;
    logic             refill;
    logic             deposit_valid;
    logic [2:0]       deposit_den;
    logic             disp_valid;
    logic [2:0]       disp_den;
    logic             disp_ready;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remain;
    logic [4:0]       stock_empty;

    change_dispense_ctrl #(
        .AMT_W     (AMT_W),
        .STOCK_W   (STOCK_W),
        .INIT_STOCK(INIT_STOCK)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .change_amt   (change_amt),
        .cancel       (cancel),
        .refill       (refill),
        .deposit_valid(deposit_valid),
        .deposit_den  (deposit_den),
        .disp_valid   (disp_valid),
        .disp_den     (disp_den),
        .disp_ready   (disp_ready),
        .busy         (busy),
        .done         (done),
        .short        (short),
        .remain       (remain),
        .stock_empty  (stock_empty)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- model state ----------------
    int    vals[5] = '{1, 5, 10, 20, 50};
    int    m_stock[5];
    int    m_remain = 0;
    step_t plan[$];
    bit    m_valid = 1'b0;
    int    cyc = 0;

    // ---------------- counters and observations ----------------
    int n_vec = 0;
    int n_err = 0;
    int seen[$];
    bit done_seen;
    int done_cyc, done_short, done_remain;
    int stall_cnt, valid_cnt, start_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Greedy plan from the amount and a snapshot of the stock.
    task automatic build_plan(input int amt);
        int rem;
        int s[5];
        bit next_den;
        rem = amt;
        s   = m_stock;
        plan.delete();
        for (int d = 4; d >= 0; d--) begin
            next_den = 1'b0;
            while (!next_den) begin
                plan.push_back('{K_SCAN, d});
                if (rem == 0) begin
                    plan.push_back('{K_DONE, 0});
                    return;
                end
                if (vals[d] <= rem && s[d] != 0) begin
                    plan.push_back('{K_OFFER, d});
                    rem -= vals[d];
                    s[d]--;
                end else if (d == 0) begin
                    plan.push_back('{K_DONE, 0});
                    return;
                end else begin
                    next_den = 1'b1;
                end
            end
        end
    endtask

    // Model update at each active edge, using the inputs held over the cycle.
    always @(posedge sys_clk) begin
        int    dec_den;
        bit    refilled;
        step_t h;
        cyc++;
        dec_den  = -1;
        refilled = 1'b0;
        if (sys_rst) begin
            plan.delete();
            m_remain = 0;
            for (int i = 0; i < 5; i++) m_stock[i] = INIT_STOCK;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (plan.size() == 0) begin
                if (start) begin
                    m_remain = int'(change_amt);
                    build_plan(int'(change_amt));
                end else if (refill) begin
                    for (int i = 0; i < 5; i++) m_stock[i] = INIT_STOCK;
                    refilled = 1'b1;
                end
            end else begin
                h = plan[0];
                if (h.kind == K_OFFER && disp_ready) begin
                    dec_den  = h.den;
                    m_remain -= vals[h.den];
                end
                if (h.kind == K_DONE) begin
                    void'(plan.pop_front());
                end else if (cancel) begin
                    plan.delete();
                    plan.push_back('{K_DONE, 0});
                end else if (!(h.kind == K_OFFER && !disp_ready)) begin
                    void'(plan.pop_front());
                end
            end
            if (!refilled) begin
                if (dec_den >= 0 && !(deposit_valid && int'(deposit_den) == dec_den))
                    m_stock[dec_den]--;
                if (deposit_valid && deposit_den < 3'd5 && int'(deposit_den) != dec_den
                    && m_stock[deposit_den] < (1 << STOCK_W) - 1)
                    m_stock[deposit_den]++;
            end
        end
    end

    // Compare and observation process, sampled mid-cycle.
    always @(negedge sys_clk) begin
        bit         e_busy, e_valid, e_done;
        int         e_den;
        logic [4:0] e_empty;
        if (m_valid) begin
            e_busy  = (plan.size() != 0);
            e_valid = e_busy && plan[0].kind == K_OFFER;
            e_done  = e_busy && plan[0].kind == K_DONE;
            e_den   = e_valid ? plan[0].den : 0;
            for (int i = 0; i < 5; i++) e_empty[i] = (m_stock[i] == 0);
            check("busy", 32'(busy), 32'(e_busy));
            check("disp_valid", 32'(disp_valid), 32'(e_valid));
            check("disp_den", 32'(disp_den), 32'(e_den));
            check("done", 32'(done), 32'(e_done));
            if (e_done) check("short", 32'(short), 32'(m_remain != 0));
            check("remain", 32'(remain), 32'(m_remain));
            check("stock_empty", 32'(stock_empty), 32'(e_empty));
        end
        if (done) begin
            done_seen   = 1'b1;
            done_cyc    = cyc;
            done_short  = int'(short);
            done_remain = int'(remain);
        end
        if (disp_valid && disp_ready) seen.push_back(int'(disp_den));
        if (disp_valid && !disp_ready) stall_cnt++;
        if (disp_valid) valid_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_payout(input int amt);
        seen.delete();
        done_seen  = 1'b0;
        stall_cnt  = 0;
        valid_cnt  = 0;
        change_amt = AMT_W'(amt);
        start      = 1'b1;
        start_cyc  = cyc;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_seen && n < 300) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst       = 1'b1;
        start         = 1'b0;
        change_amt    = '0;
        cancel        = 1'b0;
        refill        = 1'b0;
        deposit_valid = 1'b0;
        deposit_den   = 3'd0;
        disp_ready    = 1'b1;
        step();
        step();
        sys_rst = 1'b0;

        // Reset state.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_remain", 32'(remain), 32'd0);
        check("rst_stock_empty", 32'(stock_empty), 32'd0);
        step();

        // Change 6 with full stock: 5 then 1, done at start+10.
        run_payout(6);
        wait_done("c6");
        check("c6_n_issues", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("c6_first_den", 32'(seen[0]), 32'd1);
            check("c6_second_den", 32'(seen[1]), 32'd0);
        end
        check("c6_latency", 32'(done_cyc - start_cyc), 32'd10);
        check("c6_short", 32'(done_short), 32'd0);
        check("c6_remain", 32'(done_remain), 32'd0);
        check("c6_model_stock1", 32'(m_stock[1]), 32'd9);
        check("c6_model_stock0", 32'(m_stock[0]), 32'd9);

        // Change 0: done at start+2, never a request.
        run_payout(0);
        wait_done("c0");
        check("c0_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("c0_valid_cycles", 32'(valid_cnt), 32'd0);
        check("c0_short", 32'(done_short), 32'd0);

        // Drain the 5s and 1s with nine more payouts of 6.
        for (int k = 0; k < 9; k++) begin
            run_payout(6);
            wait_done("drain");
        end
        check("drain_empty", 32'(stock_empty), 32'b00011);

        // Change 6 with no 5s or 1s left -> short. Refill is held high through
        // the start cycle and the payout, so it must be dropped every time.
        refill = 1'b1;
        run_payout(6);
        wait_done("short6");
        refill = 1'b0;
        check("short6_short", 32'(done_short), 32'd1);
        check("short6_remain", 32'(done_remain), 32'd6);
        check("short6_valid_cycles", 32'(valid_cnt), 32'd0);
        check("short6_latency", 32'(done_cyc - start_cyc), 32'd6);
        step();
        check("busy_refill_ignored", 32'(stock_empty), 32'b00011);

        // Refill while idle restores everything.
        refill = 1'b1;
        step();
        refill = 1'b0;
        step();
        check("refill_empty", 32'(stock_empty), 32'd0);
        check("refill_model_stock0", 32'(m_stock[0]), 32'd10);

        // Change 75, dispenser not ready for the first request: 50, 20, 5.
        disp_ready = 1'b0;
        run_payout(75);
        repeat (7) step();
        disp_ready = 1'b1;
        wait_done("c75");
        check("c75_n_issues", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("c75_den0", 32'(seen[0]), 32'd4);
            check("c75_den1", 32'(seen[1]), 32'd3);
            check("c75_den2", 32'(seen[2]), 32'd1);
        end
        check("c75_stall", 32'(stall_cnt), 32'd6);
        check("c75_remain", 32'(done_remain), 32'd0);
        check("c75_latency", 32'(done_cyc - start_cyc), 32'd17);

        // Change 30, cancel in the same cycle as the first transfer (a 20).
        run_payout(30);
        step();
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        wait_done("cancel");
        check("cancel_latency", 32'(done_cyc - start_cyc), 32'd4);
        check("cancel_remain", 32'(done_remain), 32'd10);
        check("cancel_short", 32'(done_short), 32'd1);
        check("cancel_n_issues", 32'(seen.size()), 32'd1);
        check("cancel_model_stock3", 32'(m_stock[3]), 32'd8);

        // Deposit the 1 six times from 10: it must saturate at 15, not wrap.
        deposit_den = 3'd0;
        for (int k = 0; k < 6; k++) begin
            deposit_valid = 1'b1;
            step();
        end
        deposit_valid = 1'b0;
        step();
        check("sat_model_stock0", 32'(m_stock[0]), 32'd15);
        check("sat_not_empty", 32'(stock_empty), 32'd0);

        // Change 10: deposit a 10 in the same cycle the 10 is dispensed.
        run_payout(10);
        step();
        step();
        step();
        deposit_valid = 1'b1;
        deposit_den   = 3'd2;
        step();
        deposit_valid = 1'b0;
        wait_done("dep_disp");
        check("dep_disp_den", 32'(seen.size() == 1 ? seen[0] : 99), 32'd2);
        check("dep_disp_model_stock2", 32'(m_stock[2]), 32'd10);
        check("dep_disp_remain", 32'(done_remain), 32'd0);

        // Reset mid-payout abandons it with no done pulse.
        run_payout(75);
        step();
        step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_remain", 32'(remain), 32'd0);
        repeat (3) step();
        check("midrst_no_done", 32'(done_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
